// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the
// iterative multiply/divide unit and its HI/LO registers.
package muldiv_pkg;

   localparam int WIDTH_DEF = 32;

   localparam logic OP_MULTU = 1'b0;
   localparam logic OP_DIVU  = 1'b1;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Iteration counter width; never narrower than one bit.
   function automatic int cnt_bits(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// muldiv_datapath: shared accumulator for the radix-2
// shift-add multiply and the restoring divide.
module muldiv_datapath
   import muldiv_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             step,
   input  logic             op,
   input  logic [WIDTH-1:0] srca,
   input  logic [WIDTH-1:0] srcb,
   output logic [WIDTH-1:0] nxt_hi,
   output logic [WIDTH-1:0] nxt_lo
);

   // Upper half: partial product / remainder.
   // Lower half: multiplier bits / dividend-then-quotient.
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] acc_step;
   logic [WIDTH-1:0]   opnd;
   logic               op_q;

   logic [WIDTH-1:0]   rem;
   logic [WIDTH-1:0]   quo;
   logic [WIDTH:0]     msum;
   logic [WIDTH-1:0]   shl;
   logic [WIDTH-1:0]   diff;
   logic               fits;

   // One iteration of the latched operation.
   // A zero divisor always "fits", which yields an
   // all-ones quotient and leaves the dividend as remainder.
   always_comb begin
      rem  = acc[2*WIDTH-1:WIDTH];
      quo  = acc[WIDTH-1:0];
      msum = {1'b0, rem}
           + (quo[0] ? {1'b0, opnd} : '0);
      shl  = {rem[WIDTH-2:0], quo[WIDTH-1]};
      fits = ({rem, quo[WIDTH-1]} >= {1'b0, opnd});
      diff = shl - opnd;
      acc_step = acc;
      if (op_q == OP_MULTU) begin
         acc_step = {msum, quo[WIDTH-1:1]};
      end else if (fits) begin
         acc_step = {diff, quo[WIDTH-2:0], 1'b1};
      end else begin
         acc_step = {shl, quo[WIDTH-2:0], 1'b0};
      end
   end

   // Latch operands on load, advance one step per enable.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc  <= '0;
         opnd <= '0;
         op_q <= OP_MULTU;
      end else if (load) begin
         op_q <= op;
         if (op == OP_DIVU) begin
            opnd <= srcb;
            acc  <= {{WIDTH{1'b0}}, srca};
         end else begin
            opnd <= srca;
            acc  <= {{WIDTH{1'b0}}, srcb};
         end
      end else if (step) begin
         acc <= acc_step;
      end
   end

   // Result of the step in progress; committed on the last one.
   assign nxt_hi = acc_step[2*WIDTH-1:WIDTH];
   assign nxt_lo = acc_step[WIDTH-1:0];

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequencer, stall logic and architectural
// HI/LO registers for the iterative multu/divu unit.
module muldiv_ctrl
   import muldiv_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] srca,
   input  logic [WIDTH-1:0] srcb,
   input  logic             hilo_rd,
   output logic             busy,
   output logic             done,
   output logic             stall,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = cnt_bits(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   state_t           state;
   state_t           state_n;
   logic [CW-1:0]    cnt;
   logic             last;
   logic             load;
   logic             step;
   logic             commit;
   logic [WIDTH-1:0] nxt_hi;
   logic [WIDTH-1:0] nxt_lo;

   assign last = (cnt == CNT_LAST);

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Next state and per-cycle datapath controls.
   // start is only honoured in IDLE, so a busy unit
   // silently ignores a second issue.
   always_comb begin
      state_n = state;
      load    = 1'b0;
      step    = 1'b0;
      commit  = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_n = RUN;
               load    = 1'b1;
            end
         end
         RUN: begin
            step = 1'b1;
            if (last) begin
               state_n = IDLE;
               commit  = 1'b1;
            end
         end
      endcase
   end

   // Iteration counter; saturates at the terminal count.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= '0;
      end else if (step && !last) begin
         cnt <= cnt + CW'(1);
      end
   end

   // HI/LO only change on the final iteration edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         hi <= '0;
         lo <= '0;
      end else if (commit) begin
         hi <= nxt_hi;
         lo <= nxt_lo;
      end
   end

   // done flags the cycle right after the commit.
   always_ff @(posedge clk) begin
      if (reset) begin
         done <= 1'b0;
      end else begin
         done <= commit;
      end
   end

   assign busy  = (state == RUN);
   assign stall = busy & hilo_rd;

   muldiv_datapath #(
      .WIDTH (WIDTH)
   ) u_dp (
      .clk    (clk),
      .reset  (reset),
      .load   (load),
      .step   (step),
      .op     (op),
      .srca   (srca),
      .srcb   (srcb),
      .nxt_hi (nxt_hi),
      .nxt_lo (nxt_lo)
   );

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed table, random ops against an
// arithmetic reference, and reset / issue corner cases.
module tb_muldiv_ctrl;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic         op;
   logic [W-1:0] srca;
   logic [W-1:0] srcb;
   logic         hilo_rd;
   logic         busy;
   logic         done;
   logic         stall;
   logic [W-1:0] hi;
   logic [W-1:0] lo;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   muldiv_ctrl #(
      .WIDTH (W)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .op      (op),
      .srca    (srca),
      .srcb    (srcb),
      .hilo_rd (hilo_rd),
      .busy    (busy),
      .done    (done),
      .stall   (stall),
      .hi      (hi),
      .lo      (lo)
   );

   typedef struct {
      logic        op;
      logic [31:0] a;
      logic [31:0] b;
      int          dup_at;
      logic [63:0] exp;
   } vec_t;

   vec_t tbl[6];

   task automatic chk(input string name,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h",
                  name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // {hi, lo} as the architecture defines it.
   function automatic logic [63:0] model(
      input logic o, input logic [31:0] a,
      input logic [31:0] b);
      logic [63:0] p;
      if (o == 1'b0) begin
         p = {32'd0, a} * {32'd0, b};
      end else if (b == 32'd0) begin
         p = {a, 32'hFFFF_FFFF};
      end else begin
         p = {a % b, a / b};
      end
      return p;
   endfunction

   // Issue one op and follow it to done, cycle by cycle.
   // k counts cycles after the sampling edge E0.
   task automatic run_op(
      input  logic        o,
      input  logic [31:0] a,
      input  logic [31:0] b,
      input  int          rd1,
      input  int          rd2,
      input  int          dup_at,
      output logic [63:0] res,
      output int          lat,
      output int          bcnt,
      output int          serr,
      output int          herr);
      logic [63:0] prev;
      int k;
      prev  = {hi, lo};
      start = 1'b1;
      op    = o;
      srca  = a;
      srcb  = b;
      tick();
      start = 1'b0;
      k     = 1;
      bcnt  = 0;
      serr  = 0;
      herr  = 0;
      while (!done && k < 4 * W) begin
         hilo_rd = (k == rd1) || (k == rd2);
         start   = (k == dup_at);
         if (k == dup_at) begin
            op   = ~o;
            srca = a ^ 32'h5A5A_1234;
            srcb = b + 32'd3;
         end
         #1;
         if (stall !== (hilo_rd && k <= W)) serr++;
         if (busy === 1'b1) bcnt++;
         if ({hi, lo} !== prev) herr++;
         @(posedge clk);
         #1;
         k++;
      end
      start = 1'b0;
      lat   = k;
      hilo_rd = 1'b1;
      #1;
      chk("done_cycle_stall", 64'(stall), 64'd0);
      hilo_rd = 1'b0;
      res = {hi, lo};
   endtask

   logic [63:0] res;
   logic [63:0] exp;
   int lat, bcnt, serr, herr, dcnt;
   logic        r_op;
   logic [31:0] r_a, r_b;

   initial begin
      reset   = 1'b1;
      start   = 1'b0;
      op      = 1'b0;
      srca    = '0;
      srcb    = '0;
      hilo_rd = 1'b1;

      tbl[0] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                 0, 64'hFFFF_FFFE_0000_0001};
      tbl[1] = '{1'b1, 32'd100, 32'd7,
                 10, 64'h0000_0002_0000_000E};
      tbl[2] = '{1'b0, 32'h1234_5678, 32'h10,
                 0, 64'h0000_0001_2345_6780};
      tbl[3] = '{1'b1, 32'h0000_ABCD, 32'd0,
                 0, 64'h0000_ABCD_FFFF_FFFF};
      tbl[4] = '{1'b0, 32'd0, 32'hDEAD_BEEF,
                 10, 64'd0};
      tbl[5] = '{1'b1, 32'd5, 32'd9,
                 0, 64'h0000_0005_0000_0000};

      tick();
      tick();
      #1;
      chk("rst_busy",  64'(busy),  64'd0);
      chk("rst_done",  64'(done),  64'd0);
      chk("rst_stall", 64'(stall), 64'd0);
      chk("rst_hilo",  {hi, lo},   64'd0);
      reset   = 1'b0;
      hilo_rd = 1'b0;
      tick();

      // Table ops issue back to back from each done cycle.
      foreach (tbl[i]) begin
         run_op(tbl[i].op, tbl[i].a, tbl[i].b, 5, 20,
                tbl[i].dup_at, res, lat, bcnt, serr, herr);
         chk($sformatf("tbl%0d_result", i), res, tbl[i].exp);
         chk($sformatf("tbl%0d_latency", i),
             64'(lat), 64'(W + 1));
         chk($sformatf("tbl%0d_busy_cycles", i),
             64'(bcnt), 64'(W));
         chk($sformatf("tbl%0d_stall_pattern", i),
             64'(serr), 64'd0);
         chk($sformatf("tbl%0d_hilo_hold", i),
             64'(herr), 64'd0);
      end
      tick();
      chk("done_one_cycle", 64'(done), 64'd0);

      // Reset in RUN cycle 16 aborts and clears HI/LO.
      start = 1'b1;
      op    = 1'b0;
      srca  = 32'h0000_0777;
      srcb  = 32'h0000_0333;
      tick();
      start = 1'b0;
      repeat (15) tick();
      chk("pre_reset_busy", 64'(busy), 64'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_hilo", {hi, lo}, 64'd0);
      dcnt = 0;
      repeat (40) begin
         if (done) dcnt++;
         tick();
      end
      chk("abort_no_done", 64'(dcnt), 64'd0);

      // Random ops against the reference model.
      for (int n = 0; n < 24; n++) begin
         r_op = 1'($urandom_range(0, 1));
         r_a  = $urandom;
         case ($urandom_range(0, 3))
            0:       r_b = 32'd0;
            1:       r_b = $urandom_range(1, 15);
            default: r_b = $urandom;
         endcase
         if ($urandom_range(0, 3) == 0) r_a = r_a >> 20;
         exp = model(r_op, r_a, r_b);
         run_op(r_op, r_a, r_b, 0, 0,
                ($urandom_range(0, 1) == 1) ?
                   int'($urandom_range(1, W)) : 0,
                res, lat, bcnt, serr, herr);
         chk($sformatf("rnd%0d op%0d %h %h", n, r_op,
                       r_a, r_b), res, exp);
         chk($sformatf("rnd%0d_latency", n),
             64'(lat), 64'(W + 1));
         repeat ($urandom_range(0, 2)) tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule
